aes_dec_stream_ctrl: RTL
========================

# aes_dec_stream_ctrl

Stream controller wrapped around the 20-stage `TOPpipelined` AES-128 decryptor. It adds valid/ready handshaking on both sides and tracks which pipeline slots carry real blocks. Decrypted blocks go into an output FIFO sized so that every block already in the pipeline has a guaranteed slot. It also sequences round-10 key changes by draining the pipeline before switching keys.

## Interface
Parameters:
- `LATENCY`, 20: pipeline depth in cycles, from ciphertext in to plaintext out.
- `FIFO_DEPTH`, 32: output FIFO entries; must be ≥ `LATENCY`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `key_valid`  in  1: request to load a new round-10 key.
- `key_in`  in  128: new round-10 key.
- `key_ready`  out  1: key request accepted this cycle.
- `in_valid`  in  1: ciphertext block offered.
- `in_data`  in  128: ciphertext.
- `in_ready`  out  1: controller can accept a block.
- `out_valid`  out  1: plaintext available.
- `out_data`  out  128: plaintext.
- `out_ready`  in  1: consumer takes `out_data`.
- `pipe_ciphertext`  out  128: drives the decryptor `ciphertext` input.
- `pipe_key10`  out  128: drives the decryptor `key10` input.
- `pipe_plaintext`  in  128: decryptor `plaintext` output.
- `busy`  out  1: high when blocks are in flight or the FIFO is non-empty.

## Operation
- States: `IDLE` (no key loaded), `RUN`, `DRAIN`, `LOAD`.
- `IDLE`
  - `key_ready` = 1; `in_ready` = 0.
  - `key_valid` → latch `key_in` into the key register, go to `RUN`.
- `RUN`
  - `in_ready` = (`inflight` + `fifo_count`) < `FIFO_DEPTH`.
  - `key_valid` → go to `DRAIN`; `in_ready` = 0 from that cycle on.
- `DRAIN`
  - `in_ready` = 0.
  - When `inflight` == 0, go to `LOAD`. FIFO contents need not drain.
- `LOAD`
  - Pulse `key_ready` for one cycle, latch `key_in`, return to `RUN`.
- Accept condition: `in_valid & in_ready`.
  - Accepted cycle: `pipe_ciphertext` = `in_data`.
  - Otherwise: `pipe_ciphertext` = 0 (bubble).
- `pipe_key10` = key register at all times. It never changes while `inflight` > 0.
- Slot tracking: shift register `vld[LATENCY-1:0]`.
  - Shifts every cycle; `vld[0]` ← accept.
  - When `vld[LATENCY-1]` = 1, `pipe_plaintext` is written into the FIFO that cycle.
- `inflight` = popcount of `vld`, kept as an up/down counter of width `$clog2(LATENCY+1)`.
  - Increments on accept, decrements on FIFO write; both in one cycle → unchanged.
- FIFO write can never hit a full FIFO: the credit rule reserves a slot per in-flight block. Overflow is a design error; assert it in simulation.
- FIFO read when `out_valid & out_ready`.
  - Read and write in the same cycle with the FIFO full is legal: count unchanged.
- `busy` = (`inflight` != 0) | (`fifo_count` != 0).

## Timing
- Reset (`rst` = 0 at a rising edge) forces:
  - state `IDLE`, `vld` = 0, `inflight` = 0, FIFO empty;
  - `out_valid` = 0, `out_data` = 0, `in_ready` = 0, `key_ready` = 1, `busy` = 0;
  - key register = 0.
- Reset mid-stream discards every in-flight and buffered block. No output appears for them after release.
- Block accepted at edge t is written to the FIFO at edge t+`LATENCY`.
- `out_valid` rises after edge t+`LATENCY`+1, so minimum in→out latency is `LATENCY`+1 cycles.
- Sustained throughput is 1 block/cycle while `out_ready` = 1.
- Key change cost: the DRAIN length (≤ `LATENCY` cycles) plus 1 `LOAD` cycle.
- `in_ready` is combinational from registered state and counters only; it has no path from `in_valid`.

## Configuration
- `AES_CTRL_STATS_EN` defined:
  - adds 32-bit outputs `stat_blocks` (FIFO reads) and `stat_stalls` (cycles with `in_valid & ~in_ready`);
  - both wrap at 2^32 and clear on reset.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `aes_ctrl_pkg`:
  - `AES_BLOCK_W` = 128;
  - state enum `ctrl_state_t` {`IDLE`, `RUN`, `DRAIN`, `LOAD`};
  - default `LATENCY` and `FIFO_DEPTH` constants.
- Sub-module `aes_ctrl_fifo`: synchronous FIFO, registered output, show-ahead, depth `FIFO_DEPTH`, with count output.
- The decryptor is instantiated by the parent, not inside this block.

## Test plan
- Key = team-6 key10, then 24 back-to-back blocks from `cipher_out_6.txt`, `out_ready` = 1:
  - out[0] = 54686500636f6d706c65786974790066; out[23] = 61770000000000000000000000000000;
  - first `out_valid` exactly 21 cycles after first accept; all 24 outputs in order.
- `out_ready` = 0 throughout while streaming:
  - exactly 32 blocks accepted, then `in_ready` = 0;
  - no FIFO overflow assertion;
  - releasing `out_ready` yields all 32 outputs in order.
- Key request after 10 blocks:
  - no accept until `inflight` = 0, then a single-cycle `key_ready` pulse;
  - `pipe_key10` constant throughout the drain;
  - blocks 11+ decrypt under the new key.
- `rst` = 0 asserted with 12 in flight and 5 buffered:
  - next cycle `out_valid` = 0, `busy` = 0, state `IDLE`;
  - no stale output after re-keying.
- Random `in_valid`/`out_ready` at 50% each, 500 blocks:
  - output sequence equals the reference-model plaintexts;
  - `busy` falls within 21 cycles of the last read.
- `AES_CTRL_STATS_EN` build, 24 blocks with 7 stall cycles: `stat_blocks` = 24, `stat_stalls` = 7.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 decryptor stream controller.
package aes_ctrl_pkg;

  localparam int unsigned AES_BLOCK_W    = 128;
  localparam int unsigned DEF_LATENCY    = 20;
  localparam int unsigned DEF_FIFO_DEPTH = 32;
  localparam int unsigned STAT_W         = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/aes_ctrl_fifo.sv
// Synchronous show-ahead FIFO with a registered output stage.
// Ports:
//   clk, rst (sync, active-low)
//   wr_en / wr_data      : push into storage
//   rd_en                : consumer takes rd_data when rd_valid
//   rd_valid / rd_data   : registered head of queue
//   count                : total entries held (storage + output register)
// A pushed word reaches rd_data one cycle after it is written.
module aes_ctrl_fifo
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned W     = AES_BLOCK_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_cnt;
  logic          pop;
  logic          load;

  // Refill the output register whenever it is empty or being emptied.
  assign pop  = rd_en & rd_valid;
  assign load = (mem_cnt != '0) & (~rd_valid | pop);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers, counters and output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      assert (!(wr_en && !pop && count == CW'(DEPTH)))
        else $error("aes_ctrl_fifo: write into full FIFO");
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (load) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + CW'(wr_en) - CW'(load);
      count   <= count + CW'(wr_en) - CW'(pop);
    end
  end

endmodule

// File: rtl/aes_dec_stream_ctrl.sv
// Valid/ready stream controller around a fixed-latency AES-128 decryptor.
// Ports:
//   clk, rst (sync, active-low)
//   key_valid/key_in/key_ready : round-10 key load handshake
//   in_valid/in_data/in_ready  : ciphertext stream in
//   out_valid/out_data/out_ready : plaintext stream out
//   pipe_ciphertext/pipe_key10 : to decryptor; pipe_plaintext from it
//   busy                       : blocks in flight or buffered
//   stat_blocks/stat_stalls    : only when AES_CTRL_STATS_EN is defined
// Configuration macro: AES_CTRL_STATS_EN adds read and stall counters.
module aes_dec_stream_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY    = DEF_LATENCY,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic [AES_BLOCK_W-1:0] key_in,
  output logic                   key_ready,
  input  logic                   in_valid,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [AES_BLOCK_W-1:0] out_data,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] pipe_ciphertext,
  output logic [AES_BLOCK_W-1:0] pipe_key10,
  input  logic [AES_BLOCK_W-1:0] pipe_plaintext,
  output logic                   busy
`ifdef AES_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_blocks,
  output logic [STAT_W-1:0]      stat_stalls
`endif
);

  localparam int unsigned IW = $clog2(LATENCY + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = ((IW > CW) ? IW : CW) + 1;

  ctrl_state_t            state;
  ctrl_state_t            state_nxt;
  logic [AES_BLOCK_W-1:0] key_q;
  logic [LATENCY-1:0]     vld;
  logic [IW-1:0]          inflight;
  logic [CW-1:0]          fifo_count;
  logic                   credit_ok;
  logic                   accept;
  logic                   fifo_wr;
  logic                   key_load;

  // Every in-flight block owns a FIFO slot, so the FIFO can never overflow.
  assign credit_ok = (SW'(inflight) + SW'(fifo_count)) < SW'(FIFO_DEPTH);
  assign accept    = in_valid & in_ready;
  assign fifo_wr   = vld[LATENCY-1];

  assign pipe_ciphertext = accept ? in_data : '0;
  assign pipe_key10      = key_q;
  assign busy            = (inflight != '0) | (fifo_count != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake outputs. A pending key request closes
  // in_ready in the same cycle so the drain never exceeds the pipe depth.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    key_ready = 1'b0;
    key_load  = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          key_load  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = credit_ok & ~key_valid;
        if (key_valid) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0) state_nxt = LOAD;
      end
      LOAD: begin
        key_ready = 1'b1;
        key_load  = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key register, slot-valid shift register and in-flight counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q    <= '0;
      vld      <= '0;
      inflight <= '0;
    end else begin
      if (key_load) key_q <= key_in;
      vld <= {vld[LATENCY-2:0], accept};
      case ({accept, fifo_wr})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  aes_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (AES_BLOCK_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  (pipe_plaintext),
    .rd_en    (out_ready),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .count    (fifo_count)
  );

`ifdef AES_CTRL_STATS_EN
  logic fifo_rd;
  assign fifo_rd = out_valid & out_ready;

  // Free-running wrap-around statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_blocks <= '0;
      stat_stalls <= '0;
    end else begin
      if (fifo_rd)              stat_blocks <= stat_blocks + STAT_W'(1);
      if (in_valid && !in_ready) stat_stalls <= stat_stalls + STAT_W'(1);
    end
  end
`endif

endmodule
